// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_share_arbiter
// Purpose  : Round-robin sequencer that time-shares one external 8-bit
//            inequality comparator among NREQ requesters. One compare is
//            accepted at a time (IDLE), the registered operands drive the
//            comparator for a full cycle (CMP), and the captured not-equal
//            result is returned with the requester index as a one-cycle
//            pulse (RSP).
// Ports    : clk, rst_n                 clock, async active-low reset
//            req_valid/req_ready        per-requester handshake (ready one-hot)
//            req_a/req_b                packed operands, 8 bits per requester
//            cmp_a/cmp_b/cmp_ne         shared comparator interface
//            rsp_valid/rsp_ne/rsp_id    response pulse
//            busy                       high whenever not IDLE
//            stat_total/stat_ne         only when CMP_STATS_EN is defined
// Options  : CMP_STATS_EN adds 16-bit wrapping compare/mismatch counters.
// Revision : 1.0  initial release
// ============================================================================
module cmp_share_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          cmp_a,
    output logic [7:0]          cmp_b,
    input  logic                cmp_ne,
    output logic                rsp_valid,
    output logic                rsp_ne,
    output logic [2:0]          rsp_id,
    output logic                busy
`ifdef CMP_STATS_EN
    ,
    output logic [15:0]         stat_total,
    output logic [15:0]         stat_ne
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q,   ptr_d;
    logic [2:0]  id_q,    id_d;
    logic [7:0]  cmp_a_q, cmp_a_d;
    logic [7:0]  cmp_b_q, cmp_b_d;
    logic        rsp_ne_q, rsp_ne_d;

    // Inputs widened to the 8-requester maximum so a 3-bit index always
    // fits the vector exactly, whatever NREQ is.
    logic [7:0]  valid_ext;
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    logic        found;
    logic [2:0]  win;
    logic [3:0]  cand;
    logic        grant;

    assign valid_ext = 8'(req_valid);
    assign a_ext     = 64'(req_a);
    assign b_ext     = 64'(req_b);

    // Winner search starting at ptr and wrapping modulo NREQ. Depends only
    // on req_valid and ptr so the ready path never sees operand data.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        cand  = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (!found && valid_ext[cand[2:0]]) begin
                found = 1'b1;
                win   = cand[2:0];
            end
        end
    end

    // Ready is gated by rst_n so no grant is visible while reset is held.
    assign grant = (state_q == S_IDLE) && found && rst_n;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant && (win == 3'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        rsp_ne_d = rsp_ne_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    cmp_a_d = a_ext[{win, 3'b000} +: 8];
                    cmp_b_d = b_ext[{win, 3'b000} +: 8];
                    id_d    = win;
                    ptr_d   = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                rsp_ne_d = cmp_ne;
                state_d  = S_RSP;
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= 3'd0;
            id_q     <= 3'd0;
            cmp_a_q  <= 8'h00;
            cmp_b_q  <= 8'h00;
            rsp_ne_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
            rsp_ne_q <= rsp_ne_d;
        end
    end

    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_ne    = rsp_ne_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != S_IDLE);

`ifdef CMP_STATS_EN
    logic [15:0] stat_total_q, stat_total_d;
    logic [15:0] stat_ne_q,    stat_ne_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        stat_total_d = stat_total_q;
        stat_ne_d    = stat_ne_q;
        if (state_q == S_RSP) begin
            stat_total_d = stat_total_q + 16'd1;
            if (rsp_ne_q) begin
                stat_ne_d = stat_ne_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_q <= 16'd0;
            stat_ne_q    <= 16'd0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_ne_q    <= stat_ne_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_ne    = stat_ne_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_share_arbiter
// Purpose  : Self-checking bench for cmp_share_arbiter (NREQ = 4). Expected
//            responses are queued when a grant is driven/observed and popped
//            when rsp_valid pulses. The shared comparator is modelled here.
// Options  : CMP_STATS_EN enables the statistics-counter scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_cmp_share_arbiter;

    localparam int NREQ = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [8*NREQ-1:0]  req_a;
    logic [8*NREQ-1:0]  req_b;
    logic [NREQ-1:0]    req_ready;
    logic [7:0]         cmp_a;
    logic [7:0]         cmp_b;
    logic               cmp_ne;
    logic               rsp_valid;
    logic               rsp_ne;
    logic [2:0]         rsp_id;
    logic               busy;
`ifdef CMP_STATS_EN
    logic [15:0]        stat_total;
    logic [15:0]        stat_ne;
`endif

    typedef struct packed {
        logic [2:0] id;
        logic       ne;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    cmp_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_ne     (cmp_ne),
        .rsp_valid  (rsp_valid),
        .rsp_ne     (rsp_ne),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef CMP_STATS_EN
        ,
        .stat_total (stat_total),
        .stat_ne    (stat_ne)
`endif
    );

    // Behavioural model of the external comparator.
    assign cmp_ne = (cmp_a != cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] opa(input int i);
        return 8'(i * 16 + 3);
    endfunction

    function automatic logic [7:0] opb(input int i);
        return (i % 2 == 1) ? (opa(i) ^ 8'h40) : opa(i);
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    // Called with time at posedge+1 in IDLE; returns at posedge+1 in IDLE.
    task automatic test_single(input int id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        set_req(id, a, b);
        req_valid = 4'(1 << id);
        #1;
        checks++;
        if (req_ready !== 4'(1 << id)) begin
            errors++;
            $display("FAIL single_ready id=%0d: got %b expected %b", id, req_ready, 4'(1 << id));
        end
        sb.push_back('{id: 3'(id), ne: (a != b)});
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if ({busy, rsp_valid, cmp_a, cmp_b} !== {1'b1, 1'b0, a, b}) begin
            errors++;
            $display("FAIL single_cmp id=%0d: busy=%b rsp_valid=%b cmp_a=%h cmp_b=%h expected 1 0 %h %h",
                     id, busy, rsp_valid, cmp_a, cmp_b, a, b);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency id=%0d: rsp_valid=%b expected 1", id, rsp_valid);
        end
        e = sb.pop_front();
        if (rsp_valid === 1'b1) begin
            checks++;
            if ({rsp_id, rsp_ne} !== {e.id, e.ne}) begin
                errors++;
                $display("FAIL single_rsp: got id=%0d ne=%b expected id=%0d ne=%b",
                         rsp_id, rsp_ne, e.id, e.ne);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_pulse id=%0d: rsp_valid=%b busy=%b expected 0 0", id, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, opa(i), opb(i));
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({busy, rsp_valid, rsp_ne, rsp_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b rsp_valid=%b rsp_ne=%b rsp_id=%0d expected all 0",
                     busy, rsp_valid, rsp_ne, rsp_id);
        end
        checks++;
        if ({cmp_a, cmp_b} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_operands: cmp_a=%h cmp_b=%h expected 00 00", cmp_a, cmp_b);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int   ng;
        int   last_c;
        exp_t e;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, opa(i), opb(i));
        @(posedge clk); #1;
        rst_n  = 1'b1;
        ng     = 0;
        last_c = 0;
        for (int c = 0; c < 40 && !(ng >= 5 && sb.size() == 0); c++) begin
            if (ng >= 5) req_valid = '0;
            #1;
            if (req_ready !== 4'b0000) begin
                checks++;
                if (req_ready !== 4'(1 << (ng % 4))) begin
                    errors++;
                    $display("FAIL rr_grant %0d: got %b expected %b", ng, req_ready, 4'(1 << (ng % 4)));
                end
                if (ng > 0) begin
                    checks++;
                    if (c - last_c != 3) begin
                        errors++;
                        $display("FAIL rr_spacing %0d: got %0d cycles expected 3", ng, c - last_c);
                    end
                end
                last_c = c;
                sb.push_back('{id: 3'(ng % 4), ne: (opa(ng % 4) != opb(ng % 4))});
                ng++;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_rsp: unexpected response id=%0d expected none", rsp_id);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_ne} !== {e.id, e.ne}) begin
                        errors++;
                        $display("FAIL rr_rsp: got id=%0d ne=%b expected id=%0d ne=%b",
                                 rsp_id, rsp_ne, e.id, e.ne);
                    end
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        checks++;
        if (ng != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_complete: grants=%0d pending=%0d expected 5 and 0", ng, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_pair(input int first, input int second);
        int         ng;
        logic [3:0] clr;
        int         order[2];
        exp_t       e;
        order[0] = first;
        order[1] = second;
        for (int i = 0; i < NREQ; i++) set_req(i, opa(i), opb(i));
        req_valid = 4'((1 << first) | (1 << second));
        clr = '0;
        ng  = 0;
        for (int c = 0; c < 20 && !(ng >= 2 && sb.size() == 0); c++) begin
            req_valid = req_valid & ~clr;
            clr = '0;
            #1;
            if (req_ready !== 4'b0000) begin
                checks++;
                if (ng >= 2) begin
                    errors++;
                    $display("FAIL pair_grant: extra grant %b expected none", req_ready);
                end else begin
                    if (req_ready !== 4'(1 << order[ng])) begin
                        errors++;
                        $display("FAIL pair_grant %0d: got %b expected %b", ng, req_ready, 4'(1 << order[ng]));
                    end
                    sb.push_back('{id: 3'(order[ng]), ne: (opa(order[ng]) != opb(order[ng]))});
                    clr = req_ready;
                    ng++;
                end
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pair_rsp: unexpected response id=%0d expected none", rsp_id);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_ne} !== {e.id, e.ne}) begin
                        errors++;
                        $display("FAIL pair_rsp: got id=%0d ne=%b expected id=%0d ne=%b",
                                 rsp_id, rsp_ne, e.id, e.ne);
                    end
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        checks++;
        if (ng != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL pair_complete: grants=%0d pending=%0d expected 2 and 0", ng, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_fairness();
        test_single(3, 8'h11, 8'h11);   // pointer now 0
        test_pair(1, 2);                // pointer ends at 3
        test_pair(3, 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_req(2, 8'hA5, 8'h3C);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if ({busy, cmp_a, cmp_b} !== {1'b1, 8'hA5, 8'h3C}) begin
            errors++;
            $display("FAIL midrst_cmp: busy=%b cmp_a=%h cmp_b=%h expected 1 a5 3c", busy, cmp_a, cmp_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, rsp_ne, rsp_id, cmp_a, cmp_b} !== 22'b0) begin
            errors++;
            $display("FAIL midrst_clear: busy=%b rsp_valid=%b rsp_ne=%b rsp_id=%0d cmp_a=%h cmp_b=%h expected all 0",
                     busy, rsp_valid, rsp_ne, rsp_id, cmp_a, cmp_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_norsp: rsp_valid seen=%b expected 0", seen);
        end
        // Pointer must be back at 0: with 0 and 3 requesting, 0 wins.
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr: got %b expected 0001", req_ready);
        end
        req_valid = '0;   // withdraw before the edge
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw: busy=%b expected 0", busy);
        end
    endtask

`ifdef CMP_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_single(0, 8'h5A, 8'h5A);
        test_single(1, 8'h5A, 8'h5B);
        test_single(2, 8'h00, 8'h80);
        test_single(3, 8'h11, 8'h11);
        test_single(0, 8'hFF, 8'h00);
        checks++;
        if ({stat_total, stat_ne} !== {16'd5, 16'd3}) begin
            errors++;
            $display("FAIL stats_count: total=%0d ne=%0d expected 5 3", stat_total, stat_ne);
        end
        force dut.stat_total_q = 16'hFFFF;
        #1;
        release dut.stat_total_q;
        test_single(1, 8'h01, 8'h01);
        checks++;
        if ({stat_total, stat_ne} !== {16'h0000, 16'd3}) begin
            errors++;
            $display("FAIL stats_wrap: total=%h ne=%0d expected 0000 3", stat_total, stat_ne);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single(0, 8'h5A, 8'h5A);
        test_single(1, 8'h5A, 8'h5B);
        test_single(1, 8'h00, 8'h80);
        test_round_robin();
        test_fairness();
        test_reset_mid();
`ifdef CMP_STATS_EN
        test_stats();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: pending=%0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
